// File: rtl/cla_seq_pkg.sv
// Shared types and helpers for the sequential carry-lookahead adder.
package cla_seq_pkg;

    // Controller states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Step counter width for a given operand width (one step per nibble)
    function automatic int nib_w(input int width);
        return ((width / 4) > 1) ? $clog2(width / 4) : 1;
    endfunction

endpackage

// File: rtl/cla_seq_adder_cla4.sv
// 4-bit carry-lookahead slice shared by every nibble step of the adder.
module cla_seq_adder_cla4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       ci,
    output logic [3:0] s,
    output logic       co
);

    logic [3:0] p_s;
    logic [3:0] g_s;
    logic [4:0] c_s;

    // Propagate/generate terms and flattened lookahead carries
    always_comb begin
        p_s    = a ^ b;
        g_s    = a & b;
        c_s[0] = ci;
        c_s[1] = g_s[0] | (p_s[0] & ci);
        c_s[2] = g_s[1] | (p_s[1] & g_s[0]) | (p_s[1] & p_s[0] & ci);
        c_s[3] = g_s[2] | (p_s[2] & g_s[1]) | (p_s[2] & p_s[1] & g_s[0])
               | (p_s[2] & p_s[1] & p_s[0] & ci);
        c_s[4] = g_s[3] | (p_s[3] & g_s[2]) | (p_s[3] & p_s[2] & g_s[1])
               | (p_s[3] & p_s[2] & p_s[1] & g_s[0])
               | (p_s[3] & p_s[2] & p_s[1] & p_s[0] & ci);
        s      = p_s ^ c_s[3:0];
        co     = c_s[4];
    end

endmodule

// File: rtl/cla_seq_adder.sv
// Multi-cycle WIDTH-bit adder: one 4-bit CLA slice time-shared over WIDTH/4
// steps, with a carry register linking the steps and valid/ready handshakes.
// Optional subtract mode and signed-overflow output: define CLA_SEQ_SUB_EN.
module cla_seq_adder
    import cla_seq_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
`ifdef CLA_SEQ_SUB_EN
    ,
    output logic             ovf
`endif
);

    localparam int NIB   = WIDTH / 4;
    localparam int CNT_W = nib_w(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NIB - 1);

    state_e           state_r;
    state_e           state_s;
    logic [WIDTH-1:0] a_sh_r;
    logic [WIDTH-1:0] b_sh_r;
    logic [CNT_W-1:0] cnt_r;
    logic             carry_r;
    logic [WIDTH-1:0] sum_r;
    logic             cout_r;
    logic             in_ready_r;
    logic             out_valid_r;
    logic             busy_r;
    logic [WIDTH-1:0] b_load_s;
    logic             c_load_s;
    logic             accept_s;
    logic             step_s;
    logic             last_s;
    logic [3:0]       slice_s_s;
    logic             slice_co_s;

    // The single shared datapath slice
    cla_seq_adder_cla4 u_slice (
        .a  (a_sh_r[3:0]),
        .b  (b_sh_r[3:0]),
        .ci (carry_r),
        .s  (slice_s_s),
        .co (slice_co_s)
    );

`ifdef CLA_SEQ_SUB_EN
    logic ovf_r;
    logic msb_cin_s;

    // Subtract loads ~b with a forced carry-in of one
    always_comb begin
        if (sub) begin
            b_load_s = ~b;
            c_load_s = 1'b1;
        end else begin
            b_load_s = b;
            c_load_s = cin;
        end
        msb_cin_s = a_sh_r[3] ^ b_sh_r[3] ^ slice_s_s[3];
    end
`else
    logic unused_sub_s;
    assign unused_sub_s = sub;

    // Add-only build: operands pass straight through
    always_comb begin
        b_load_s = b;
        c_load_s = cin;
    end
`endif

    // Step qualifiers
    always_comb begin
        accept_s = (state_r == IDLE) && in_valid;
        step_s   = (state_r == RUN);
        last_s   = step_s && (cnt_r == CNT_LAST);
    end

    // Next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE:    state_s = in_valid ? RUN : IDLE;
            RUN:     state_s = (cnt_r == CNT_LAST) ? DONE : RUN;
            DONE:    state_s = out_ready ? IDLE : DONE;
            default: state_s = IDLE;
        endcase
    end

    // State register and registered handshake/status outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            in_ready_r  <= (state_s == IDLE);
            out_valid_r <= (state_s == DONE);
            busy_r      <= (state_s != IDLE);
        end
    end

    // Operand load, nibble stepping and result capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh_r  <= '0;
            b_sh_r  <= '0;
            cnt_r   <= '0;
            carry_r <= 1'b0;
            sum_r   <= '0;
            cout_r  <= 1'b0;
`ifdef CLA_SEQ_SUB_EN
            ovf_r   <= 1'b0;
`endif
        end else if (accept_s) begin
            a_sh_r  <= a;
            b_sh_r  <= b_load_s;
            carry_r <= c_load_s;
            cnt_r   <= '0;
        end else if (step_s) begin
            sum_r   <= {slice_s_s, sum_r[WIDTH-1:4]};
            carry_r <= slice_co_s;
            a_sh_r  <= {4'b0000, a_sh_r[WIDTH-1:4]};
            b_sh_r  <= {4'b0000, b_sh_r[WIDTH-1:4]};
            cnt_r   <= cnt_r + CNT_W'(1);
            if (last_s) begin
                cout_r <= slice_co_s;
`ifdef CLA_SEQ_SUB_EN
                ovf_r  <= msb_cin_s ^ slice_co_s;
`endif
            end else begin
                cout_r <= cout_r;
            end
        end else begin
            sum_r   <= sum_r;
            cout_r  <= cout_r;
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign busy      = busy_r;
    assign sum       = sum_r;
    assign cout      = cout_r;
`ifdef CLA_SEQ_SUB_EN
    assign ovf       = ovf_r;
`endif

endmodule
